trap_return_unit: RTL and testbench

Executes MRET/SRET at commit: the return path complementing the trap-entry privilege router. Accepts one xRET from the commit stage and checks its legality against the current privilege and mstatus.TSR. It then holds a pipeline flush until acknowledged, and in a single commit cycle writes the new privilege, the updated mstatus stack fields and the redirect PC. Sits between the commit stage, the CSR file and the front-end redirect port.

---
 rtl/priv_pkg.sv | 13 +
 rtl/trap_return_unit_if.sv | 49 ++++
 rtl/xret_check.sv | 52 +++++
 rtl/trap_return_unit.sv | 114 +++++++++++
 tb/tb_trap_return_unit.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/priv_pkg.sv
// Privilege encodings, trap cause and xRET sequencer states shared by the
// trap-entry router and the trap-return unit.
package priv_pkg;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  localparam int unsigned ILLEGAL_INSN = 2;

  typedef enum logic [1:0] {IDLE, ILLEGAL, FLUSH, COMMIT} state_e;

endpackage

// File: rtl/trap_return_unit_if.sv
// Commit / CSR / redirect bundle of the trap-return unit; the unit takes the
// slave side, the commit stage and CSR file drive the master side.
interface trap_return_unit_if #(
  parameter int unsigned PC_WIDTH = 32
);

  logic                xret_valid_i;
  logic                xret_is_mret_i;
  logic                xret_ready_o;
  logic [1:0]          current_privilege_i;
  logic [1:0]          mstatus_mpp_i;
  logic                mstatus_spp_i;
  logic                mstatus_mpie_i;
  logic                mstatus_spie_i;
  logic                mstatus_tsr_i;
  logic [PC_WIDTH-1:0] mepc_i;
  logic [PC_WIDTH-1:0] sepc_i;
  logic                flush_req_o;
  logic                flush_ack_i;
  logic                illegal_o;
  logic                commit_o;
  logic [1:0]          priv_new_o;
  logic                mie_o;
  logic                mpie_o;
  logic [1:0]          mpp_o;
  logic                sie_o;
  logic                spie_o;
  logic                spp_o;
  logic                mprv_clr_o;
  logic                mret_o;
  logic [PC_WIDTH-1:0] redirect_pc_o;

  modport slave (
    input  xret_valid_i, xret_is_mret_i, current_privilege_i,
    input  mstatus_mpp_i, mstatus_spp_i, mstatus_mpie_i, mstatus_spie_i, mstatus_tsr_i,
    input  mepc_i, sepc_i, flush_ack_i,
    output xret_ready_o, flush_req_o, illegal_o, commit_o, priv_new_o,
    output mie_o, mpie_o, mpp_o, sie_o, spie_o, spp_o, mprv_clr_o, mret_o, redirect_pc_o
  );

  modport master (
    output xret_valid_i, xret_is_mret_i, current_privilege_i,
    output mstatus_mpp_i, mstatus_spp_i, mstatus_mpie_i, mstatus_spie_i, mstatus_tsr_i,
    output mepc_i, sepc_i, flush_ack_i,
    input  xret_ready_o, flush_req_o, illegal_o, commit_o, priv_new_o,
    input  mie_o, mpie_o, mpp_o, sie_o, spie_o, spp_o, mprv_clr_o, mret_o, redirect_pc_o
  );

endinterface

// File: rtl/xret_check.sv
// Combinational xRET legality check and computation of the post-return
// privilege and mstatus stack fields.
module xret_check
  import priv_pkg::*;
(
  input  logic       is_mret_i,
  input  logic [1:0] priv_i,
  input  logic [1:0] mpp_i,
  input  logic       spp_i,
  input  logic       mpie_i,
  input  logic       spie_i,
  input  logic       tsr_i,
  output logic       illegal_o,
  output logic [1:0] priv_new_o,
  output logic       mie_o,
  output logic       mpie_o,
  output logic [1:0] mpp_o,
  output logic       sie_o,
  output logic       spie_o,
  output logic       spp_o,
  output logic       mprv_clr_o
);

  always_comb begin
    illegal_o  = 1'b0;
    priv_new_o = PRIV_U;
    mie_o      = 1'b0;
    mpie_o     = 1'b0;
    mpp_o      = PRIV_U;
    sie_o      = 1'b0;
    spie_o     = 1'b0;
    spp_o      = 1'b0;
    mprv_clr_o = 1'b0;
    if (is_mret_i) begin
      illegal_o  = (priv_i != PRIV_M);
      // MPP=10 is reserved and returns to U.
      priv_new_o = (mpp_i == 2'b10) ? PRIV_U : mpp_i;
      mie_o      = mpie_i;
      mpie_o     = 1'b1;
      mpp_o      = PRIV_U;
      mprv_clr_o = (priv_new_o != PRIV_M);
    end else begin
      illegal_o  = (priv_i == PRIV_U) || ((priv_i == PRIV_S) && tsr_i);
      priv_new_o = {1'b0, spp_i};
      sie_o      = spie_i;
      spie_o     = 1'b1;
      spp_o      = 1'b0;
      mprv_clr_o = 1'b1;
    end
  end

endmodule

// File: rtl/trap_return_unit.sv
// MRET/SRET commit sequencer: checks legality, snapshots the return state,
// holds a pipeline flush until acknowledged and then commits in one cycle.
module trap_return_unit
  import priv_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 32
) (
  input logic              cpu_clock_i,
  input logic              rst_ni,
  trap_return_unit_if.slave bus
);

  state_e state_q, state_d;
  logic   accept;
  logic   load;

  logic       chk_illegal;
  logic [1:0] chk_priv;
  logic       chk_mie, chk_mpie, chk_sie, chk_spie, chk_spp, chk_mprv;
  logic [1:0] chk_mpp;
  logic [PC_WIDTH-1:0] epc, pc_d;

  logic [1:0]          priv_q, mpp_q;
  logic                mie_q, mpie_q, sie_q, spie_q, spp_q, mprv_q, mret_q;
  logic [PC_WIDTH-1:0] pc_q;

  xret_check u_xret_check (
    .is_mret_i  (bus.xret_is_mret_i),
    .priv_i     (bus.current_privilege_i),
    .mpp_i      (bus.mstatus_mpp_i),
    .spp_i      (bus.mstatus_spp_i),
    .mpie_i     (bus.mstatus_mpie_i),
    .spie_i     (bus.mstatus_spie_i),
    .tsr_i      (bus.mstatus_tsr_i),
    .illegal_o  (chk_illegal),
    .priv_new_o (chk_priv),
    .mie_o      (chk_mie),
    .mpie_o     (chk_mpie),
    .mpp_o      (chk_mpp),
    .sie_o      (chk_sie),
    .spie_o     (chk_spie),
    .spp_o      (chk_spp),
    .mprv_clr_o (chk_mprv)
  );

  assign epc  = bus.xret_is_mret_i ? bus.mepc_i : bus.sepc_i;
  assign pc_d = {epc[PC_WIDTH-1:2], 2'b00};

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.xret_valid_i) begin
          accept  = 1'b1;
          state_d = chk_illegal ? ILLEGAL : FLUSH;
        end
      end
      ILLEGAL: state_d = IDLE;
      FLUSH:   if (bus.flush_ack_i) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Illegal xRETs leave the write outputs untouched.
  assign load = accept && !chk_illegal;

  always_ff @(posedge cpu_clock_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      priv_q  <= PRIV_U;
      mie_q   <= 1'b0;
      mpie_q  <= 1'b0;
      mpp_q   <= PRIV_U;
      sie_q   <= 1'b0;
      spie_q  <= 1'b0;
      spp_q   <= 1'b0;
      mprv_q  <= 1'b0;
      mret_q  <= 1'b0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        priv_q <= chk_priv;
        mie_q  <= chk_mie;
        mpie_q <= chk_mpie;
        mpp_q  <= chk_mpp;
        sie_q  <= chk_sie;
        spie_q <= chk_spie;
        spp_q  <= chk_spp;
        mprv_q <= chk_mprv;
        mret_q <= bus.xret_is_mret_i;
        pc_q   <= pc_d;
      end
    end
  end

  assign bus.xret_ready_o  = (state_q == IDLE);
  assign bus.illegal_o     = (state_q == ILLEGAL);
  assign bus.flush_req_o   = (state_q == FLUSH);
  assign bus.commit_o      = (state_q == COMMIT);
  assign bus.priv_new_o    = priv_q;
  assign bus.mie_o         = mie_q;
  assign bus.mpie_o        = mpie_q;
  assign bus.mpp_o         = mpp_q;
  assign bus.sie_o         = sie_q;
  assign bus.spie_o        = spie_q;
  assign bus.spp_o         = spp_q;
  assign bus.mprv_clr_o    = mprv_q;
  assign bus.mret_o        = mret_q;
  assign bus.redirect_pc_o = pc_q;

endmodule

// File: tb/tb_trap_return_unit.sv
// Self-checking bench for trap_return_unit: directed table, random xRETs
// against a reference model, and reset/snapshot corner sequences.
module tb_trap_return_unit;
  import priv_pkg::*;

  typedef struct {
    logic        is_mret;
    logic [1:0]  priv;
    logic [1:0]  mpp;
    logic        spp, mpie, spie, tsr;
    logic [31:0] mepc, sepc;
  } xin_t;

  typedef struct {
    logic        illegal;
    logic [1:0]  priv;
    logic        mie, mpie;
    logic [1:0]  mpp;
    logic        sie, spie, spp, mprv;
    logic [31:0] pc;
  } xexp_t;

  typedef struct {
    xin_t  in;
    int    ack_dly;
    xexp_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  xexp_t last;
  vec_t  tbl [10];

  trap_return_unit_if #(.PC_WIDTH(32)) bus ();

  trap_return_unit #(.PC_WIDTH(32)) dut (
    .cpu_clock_i (clk),
    .rst_ni      (rst_n),
    .bus         (bus)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the xRET rules stated directly in terms of the architecture.
  function automatic xexp_t model(input xin_t x);
    xexp_t e = '{default: '0};
    if (x.is_mret) begin
      e.illegal = (x.priv != 2'b11);
      e.priv    = (x.mpp == 2'b10) ? 2'b00 : x.mpp;
      e.mie     = x.mpie;
      e.mpie    = 1'b1;
      e.mpp     = 2'b00;
      e.mprv    = (e.priv != 2'b11);
      e.pc      = x.mepc & ~32'h3;
    end else begin
      e.illegal = (x.priv == 2'b00) || (x.priv == 2'b01 && x.tsr);
      e.priv    = {1'b0, x.spp};
      e.sie     = x.spie;
      e.spie    = 1'b1;
      e.spp     = 1'b0;
      e.mprv    = 1'b1;
      e.pc      = x.sepc & ~32'h3;
    end
    return e;
  endfunction

  task automatic drive(input xin_t x);
    bus.xret_is_mret_i      = x.is_mret;
    bus.current_privilege_i = x.priv;
    bus.mstatus_mpp_i       = x.mpp;
    bus.mstatus_spp_i       = x.spp;
    bus.mstatus_mpie_i      = x.mpie;
    bus.mstatus_spie_i      = x.spie;
    bus.mstatus_tsr_i       = x.tsr;
    bus.mepc_i              = x.mepc;
    bus.sepc_i              = x.sepc;
  endtask

  // Starts just after a rising edge with the DUT idle; returns likewise.
  task automatic run_xret(input xin_t x, input xexp_t e, input int ack_dly,
                          input bit hold, input bit early, input bit scramble);
    drive(x);
    bus.xret_valid_i = 1'b1;
    if (early) bus.flush_ack_i = 1'b1;
    @(negedge clk);
    chk("ready_idle", 32'(bus.xret_ready_o), 32'd1);
    chk("idle_no_commit", 32'(bus.commit_o), 32'd0);
    chk("idle_no_illegal", 32'(bus.illegal_o), 32'd0);
    chk("idle_no_flush", 32'(bus.flush_req_o), 32'd0);
    @(posedge clk); #1;
    if (!hold) bus.xret_valid_i = 1'b0;
    if (scramble) begin
      bus.mepc_i              = $urandom;
      bus.sepc_i              = $urandom;
      bus.mstatus_mpp_i       = 2'($urandom);
      bus.mstatus_spp_i       = 1'($urandom);
      bus.mstatus_mpie_i      = 1'($urandom);
      bus.mstatus_spie_i      = 1'($urandom);
      bus.xret_is_mret_i      = 1'($urandom);
      bus.current_privilege_i = 2'($urandom);
    end
    if (e.illegal) begin
      @(negedge clk);
      chk("illegal_pulse", 32'(bus.illegal_o), 32'd1);
      chk("illegal_no_flush", 32'(bus.flush_req_o), 32'd0);
      chk("illegal_no_commit", 32'(bus.commit_o), 32'd0);
      chk("illegal_not_ready", 32'(bus.xret_ready_o), 32'd0);
      chk("illegal_priv_kept", 32'(bus.priv_new_o), 32'(last.priv));
      chk("illegal_pc_kept", bus.redirect_pc_o, last.pc);
      @(posedge clk); #1;
      bus.flush_ack_i = 1'b0;
    end else begin
      for (int c = 1; c <= ack_dly; c++) begin
        if (c == ack_dly) bus.flush_ack_i = 1'b1;
        @(negedge clk);
        chk("flush_req", 32'(bus.flush_req_o), 32'd1);
        chk("flush_no_commit", 32'(bus.commit_o), 32'd0);
        chk("flush_not_ready", 32'(bus.xret_ready_o), 32'd0);
        @(posedge clk); #1;
      end
      bus.flush_ack_i = 1'b0;
      @(negedge clk);
      chk("commit", 32'(bus.commit_o), 32'd1);
      chk("commit_no_flush", 32'(bus.flush_req_o), 32'd0);
      chk("commit_not_ready", 32'(bus.xret_ready_o), 32'd0);
      chk("priv_new", 32'(bus.priv_new_o), 32'(e.priv));
      chk("mprv_clr", 32'(bus.mprv_clr_o), 32'(e.mprv));
      chk("mret", 32'(bus.mret_o), 32'(x.is_mret));
      chk("redirect_pc", bus.redirect_pc_o, e.pc);
      if (x.is_mret) begin
        chk("mie", 32'(bus.mie_o), 32'(e.mie));
        chk("mpie", 32'(bus.mpie_o), 32'(e.mpie));
        chk("mpp", 32'(bus.mpp_o), 32'(e.mpp));
      end else begin
        chk("sie", 32'(bus.sie_o), 32'(e.sie));
        chk("spie", 32'(bus.spie_o), 32'(e.spie));
        chk("spp", 32'(bus.spp_o), 32'(e.spp));
      end
      last = e;
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(bus.xret_ready_o), 32'd1);
    chk({tag, "_flush"}, 32'(bus.flush_req_o), 32'd0);
    chk({tag, "_illegal"}, 32'(bus.illegal_o), 32'd0);
    chk({tag, "_commit"}, 32'(bus.commit_o), 32'd0);
    chk({tag, "_mret"}, 32'(bus.mret_o), 32'd0);
    chk({tag, "_mprv"}, 32'(bus.mprv_clr_o), 32'd0);
    chk({tag, "_priv"}, 32'(bus.priv_new_o), 32'd0);
    chk({tag, "_stack"}, 32'({bus.mie_o, bus.mpie_o, bus.mpp_o, bus.sie_o, bus.spie_o,
                              bus.spp_o}), 32'd0);
    chk({tag, "_pc"}, bus.redirect_pc_o, 32'd0);
  endtask

  initial begin
    xin_t  x;
    xexp_t e;
    int    p;
    // is_mret priv mpp spp mpie spie tsr mepc sepc | ack | illegal priv mie mpie mpp
    //   sie spie spp mprv pc
    tbl[0] = '{'{1'b1, 2'b11, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0103, 32'h0}, 3,
               '{1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0100}};
    tbl[1] = '{'{1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_1000}, 1,
               '{1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_1000}};
    tbl[2] = '{'{1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_2000}, 1,
               '{1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0}};
    tbl[3] = '{'{1'b1, 2'b00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_3000, 32'h0}, 1,
               '{1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0}};
    tbl[4] = '{'{1'b1, 2'b11, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_2002, 32'h0}, 2,
               '{1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_2000}};
    tbl[5] = '{'{1'b1, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0044, 32'h0}, 1,
               '{1'b0, 2'b11, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0044}};
    tbl[6] = '{'{1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF}, 4,
               '{1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC}};
    tbl[7] = '{'{1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_4000}, 1,
               '{1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0}};
    tbl[8] = '{'{1'b1, 2'b01, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_5000, 32'h0}, 1,
               '{1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0}};
    tbl[9] = '{'{1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0003}, 2,
               '{1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0}};

    last = '{default: '0};
    bus.xret_valid_i = 1'b0;
    bus.flush_ack_i  = 1'b0;
    drive('{default: '0});

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      if (tbl[i].exp.illegal)
        $display("vector %0d: illegal xRET, mcause %0d expected", i, ILLEGAL_INSN);
      run_xret(tbl[i].in, tbl[i].exp, tbl[i].ack_dly, 1'b0, 1'b0, 1'b0);
    end

    // Ack held high before the request: commit no earlier than cycle 2.
    run_xret(tbl[0].in, tbl[0].exp, 1, 1'b0, 1'b1, 1'b0);

    // Snapshot with valid held: CSR inputs change during FLUSH, back-to-back xRETs.
    run_xret(tbl[0].in, tbl[0].exp, 3, 1'b1, 1'b0, 1'b1);
    run_xret(tbl[4].in, tbl[4].exp, 2, 1'b1, 1'b0, 1'b1);
    run_xret(tbl[6].in, tbl[6].exp, 1, 1'b0, 1'b0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      x.is_mret = 1'($urandom);
      p         = $urandom_range(0, 2);
      x.priv    = (p == 2) ? 2'b11 : 2'(p);
      x.mpp     = 2'($urandom);
      x.spp     = 1'($urandom);
      x.mpie    = 1'($urandom);
      x.spie    = 1'($urandom);
      x.tsr     = 1'($urandom);
      x.mepc    = $urandom;
      x.sepc    = $urandom;
      e = model(x);
      p = $urandom_range(1, 4);
      run_xret(x, e, p, 1'($urandom), (p == 1) && 1'($urandom), 1'($urandom));
    end
    bus.xret_valid_i = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of FLUSH drops the xRET.
    drive(tbl[5].in);
    bus.xret_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.xret_valid_i = 1'b0;
    @(posedge clk); #3;
    chk("pre_reset_flush", 32'(bus.flush_req_o), 32'd1);
    rst_n = 1'b0;
    bus.flush_ack_i = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_reset_no_commit", 32'(bus.commit_o), 32'd0);
      chk("post_reset_ready", 32'(bus.xret_ready_o), 32'd1);
      chk("post_reset_no_flush", 32'(bus.flush_req_o), 32'd0);
    end
    @(posedge clk); #1;
    bus.flush_ack_i = 1'b0;
    last = '{default: '0};
    run_xret(tbl[8].in, tbl[8].exp, 1, 1'b0, 1'b0, 1'b0);
    run_xret(tbl[1].in, tbl[1].exp, 2, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
